// File: rtl/exe_pkg.sv
// Shared definitions for the EXE program sequencer: instruction layout, kind codes,
// EXE control widths and FSM state encoding.
package exe_pkg;

  localparam int unsigned INSTR_W = 20;
  localparam int unsigned OPER_W  = 3;
  localparam int unsigned REG_W   = 4;
  localparam int unsigned DATA_W  = 6;
  localparam int unsigned FLAG_W  = 4;
  localparam int unsigned STEP_W  = 8;
  localparam int unsigned LAT_W   = 3;

  localparam int unsigned KIND_LSB = 18;
  localparam int unsigned OPER_LSB = 15;
  localparam int unsigned REG2_LSB = 11;
  localparam int unsigned REG0_LSB = 7;
  localparam int unsigned REG1_LSB = 3;
  localparam int unsigned DATA_LSB = 5;
  localparam int unsigned BSEL_LSB = 16;
  localparam int unsigned BPOL_BIT = 15;

  typedef enum logic [1:0] {
    KIND_ALU_R = 2'b00,
    KIND_ALU_I = 2'b01,
    KIND_BR    = 2'b10,
    KIND_HALT  = 2'b11
  } kind_e;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StIssue,
    StWait,
    StDone
  } state_e;

endpackage

// File: rtl/exe_instr_decode.sv
// Combinational instruction decoder: splits an instruction word into EXE controls
// and branch fields. Unused controls for a given kind are driven to 0.
module exe_instr_decode
  import exe_pkg::*;
#(
  parameter int unsigned PC_W = 4
) (
  input  logic [INSTR_W-1:0] i_instr,
  output kind_e              o_kind,
  output logic [OPER_W-1:0]  o_oper,
  output logic [REG_W-1:0]   o_reg0,
  output logic [REG_W-1:0]   o_reg1,
  output logic [REG_W-1:0]   o_reg2,
  output logic [DATA_W-1:0]  o_data,
  output logic               o_imm,
  output logic [1:0]         o_br_sel,
  output logic               o_br_pol,
  output logic [PC_W-1:0]    o_br_target
);

  assign o_kind      = kind_e'(i_instr[KIND_LSB +: 2]);
  assign o_br_sel    = i_instr[BSEL_LSB +: 2];
  assign o_br_pol    = i_instr[BPOL_BIT];
  assign o_br_target = i_instr[PC_W-1:0];

  always_comb begin
    o_oper = '0;
    o_reg0 = '0;
    o_reg1 = '0;
    o_reg2 = '0;
    o_data = '0;
    o_imm  = 1'b0;
    unique case (o_kind)
      KIND_ALU_R: begin
        o_oper = i_instr[OPER_LSB +: OPER_W];
        o_reg2 = i_instr[REG2_LSB +: REG_W];
        o_reg0 = i_instr[REG0_LSB +: REG_W];
        o_reg1 = i_instr[REG1_LSB +: REG_W];
      end
      KIND_ALU_I: begin
        o_oper = i_instr[OPER_LSB +: OPER_W];
        o_reg2 = i_instr[REG2_LSB +: REG_W];
        o_data = i_instr[DATA_LSB +: DATA_W];
        o_imm  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/exe_sequencer.sv
// Program sequencer for the EXE datapath: fetches from a sync ROM, issues one ALU op at a
// time, captures flags, and handles flag-conditional branches, HALT and a step watchdog.
module exe_sequencer
  import exe_pkg::*;
#(
  parameter int unsigned PC_W     = 4,
  parameter int unsigned EXE_LAT  = 1,
  parameter int unsigned MAX_STEP = 255
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [PC_W-1:0]    i_pc_start,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_timeout,
  output logic               o_rom_en,
  output logic [PC_W-1:0]    o_rom_addr,
  input  logic [INSTR_W-1:0] i_rom_data,
  output logic               o_exe_en,
  output logic [OPER_W-1:0]  o_oper,
  output logic [REG_W-1:0]   o_reg0,
  output logic [REG_W-1:0]   o_reg1,
  output logic [REG_W-1:0]   o_reg2,
  output logic [DATA_W-1:0]  o_data,
  output logic               o_imm,
  input  logic [FLAG_W-1:0]  i_flag,
  output logic [FLAG_W-1:0]  o_flag_q,
  output logic [PC_W-1:0]    o_pc
);

  localparam logic [LAT_W-1:0]  LAT_LOAD = LAT_W'(EXE_LAT);
  localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(MAX_STEP);

  state_e              r_state, w_state_nxt;
  logic [PC_W-1:0]     r_pc, w_pc_nxt, w_pc_inc;
  logic [INSTR_W-1:0]  r_ir, w_ir_nxt, w_instr;
  logic [FLAG_W-1:0]   r_flag, w_flag_nxt;
  logic [STEP_W-1:0]   r_step, w_step_nxt, w_step_inc;
  logic [LAT_W-1:0]    r_lat, w_lat_nxt;
  logic                r_timeout, w_timeout_nxt;
  logic                w_step_hit, w_taken, w_issue;

  kind_e               w_kind;
  logic [OPER_W-1:0]   w_oper;
  logic [REG_W-1:0]    w_reg0, w_reg1, w_reg2;
  logic [DATA_W-1:0]   w_data;
  logic                w_imm;
  logic [1:0]          w_br_sel;
  logic                w_br_pol;
  logic [PC_W-1:0]     w_br_target;

  // DECODE steers on the word arriving from the ROM; ISSUE drives from the latched IR.
  assign w_instr = (r_state == StDecode) ? i_rom_data : r_ir;

  exe_instr_decode #(
    .PC_W (PC_W)
  ) u_decode (
    .i_instr     (w_instr),
    .o_kind      (w_kind),
    .o_oper      (w_oper),
    .o_reg0      (w_reg0),
    .o_reg1      (w_reg1),
    .o_reg2      (w_reg2),
    .o_data      (w_data),
    .o_imm       (w_imm),
    .o_br_sel    (w_br_sel),
    .o_br_pol    (w_br_pol),
    .o_br_target (w_br_target)
  );

  assign w_pc_inc   = r_pc + 1'b1;
  assign w_step_inc = r_step + 1'b1;
  assign w_step_hit = (w_step_inc == STEP_MAX);
  assign w_taken    = (r_flag[w_br_sel] == w_br_pol);
  assign w_issue    = (r_state == StIssue);

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_ir_nxt      = r_ir;
    w_flag_nxt    = r_flag;
    w_step_nxt    = r_step;
    w_lat_nxt     = r_lat;
    w_timeout_nxt = r_timeout;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_nxt   = StFetch;
          w_pc_nxt      = i_pc_start;
          w_flag_nxt    = '0;
          w_step_nxt    = '0;
          w_timeout_nxt = 1'b0;
        end
      end
      StFetch: w_state_nxt = StDecode;
      StDecode: begin
        w_ir_nxt = i_rom_data;
        unique case (w_kind)
          KIND_ALU_R, KIND_ALU_I: w_state_nxt = StIssue;
          KIND_BR: begin
            w_pc_nxt      = w_taken ? w_br_target : w_pc_inc;
            w_step_nxt    = w_step_inc;
            w_state_nxt   = w_step_hit ? StDone : StFetch;
            w_timeout_nxt = r_timeout | w_step_hit;
          end
          default: w_state_nxt = StDone;
        endcase
      end
      StIssue: begin
        w_lat_nxt   = LAT_LOAD;
        w_state_nxt = StWait;
      end
      StWait: begin
        if (r_lat <= LAT_W'(1)) begin
          w_flag_nxt    = i_flag;
          w_pc_nxt      = w_pc_inc;
          w_step_nxt    = w_step_inc;
          w_state_nxt   = w_step_hit ? StDone : StFetch;
          w_timeout_nxt = r_timeout | w_step_hit;
        end else begin
          w_lat_nxt = r_lat - 1'b1;
        end
      end
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_pc      <= '0;
      r_ir      <= '0;
      r_flag    <= '0;
      r_step    <= '0;
      r_lat     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_ir      <= w_ir_nxt;
      r_flag    <= w_flag_nxt;
      r_step    <= w_step_nxt;
      r_lat     <= w_lat_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  always_comb begin
    o_busy     = (r_state != StIdle);
    o_done     = (r_state == StDone);
    o_timeout  = r_timeout;
    o_rom_en   = (r_state == StFetch);
    o_rom_addr = r_pc;
    o_exe_en   = w_issue;
    o_oper     = w_issue ? w_oper : '0;
    o_reg0     = w_issue ? w_reg0 : '0;
    o_reg1     = w_issue ? w_reg1 : '0;
    o_reg2     = w_issue ? w_reg2 : '0;
    o_data     = w_issue ? w_data : '0;
    o_imm      = w_issue & w_imm;
    o_flag_q   = r_flag;
    o_pc       = r_pc;
  end

endmodule
